// File: rtl/bank_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bank_reader : strided bank read initiator with 2-entry credit-gated FWFT FIFO
// Rev 1.0
// ============================================================================
module bank_reader #(
  parameter int W = 128,
  parameter int A = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [A-1:0] base_addr_i,
  input  logic [A-1:0] stride_i,
  input  logic [A:0]   count_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         rd_en_o,
  output logic [A-1:0] rd_addr_o,
  input  logic [W-1:0] rd_word_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [A-1:0]   stride_q, stride_d;
  logic [A:0]     remaining_q, remaining_d;
  logic           inflight_q, inflight_d;
  logic           inflight_last_q, inflight_last_d;
  logic           done_q, done_d;

  logic [W-1:0]   data_q [2];
  logic           last_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     occ_q;

  logic           w_pop;
  logic           w_push;
  logic           w_flush;
  logic           w_issue;
  logic [2:0]     w_credit;
  logic           w_final_issue;

  // Slots already committed: stored words plus the in-flight return, net of this cycle's pop.
  assign w_pop         = out_valid_o & out_ready_i;
  assign w_credit      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_flush       = abort_i & (state_q != ST_IDLE);
  assign w_issue       = (state_q == ST_RUN) & ~abort_i & (w_credit < 3'd2);
  assign w_push        = inflight_q & ~w_flush;
  assign w_final_issue = (remaining_q == {{A{1'b0}}, 1'b1});

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    stride_d        = stride_q;
    remaining_d     = remaining_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    done_d          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          addr_d      = base_addr_i;
          stride_d    = stride_i;
          remaining_d = count_i;
          if (count_i != '0) begin
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (w_issue) begin
          addr_d          = addr_q + stride_q;
          remaining_d     = remaining_q - {{A{1'b0}}, 1'b1};
          inflight_d      = 1'b1;
          inflight_last_d = w_final_issue;
          if (w_final_issue) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (w_pop && out_last_o) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      stride_q        <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      stride_q        <= stride_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (w_flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (w_push) begin
        data_q[wr_ptr_q] <= rd_word_i;
        last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // The credit gate must make a push into a full, non-popping FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (occ_q == 2'd2) && !w_pop));

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign rd_en_o     = w_issue;
  assign rd_addr_o   = addr_q;
  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = data_q[rd_ptr_q];
  assign out_last_o  = last_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_bank_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_bank_reader : directed self-checking bench for bank_reader
// Rev 1.0
// ============================================================================
module tb_bank_reader;

  localparam int W = 128;
  localparam int A = 9;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         start     = 1'b0;
  logic         abort     = 1'b0;
  logic [A-1:0] base      = '0;
  logic [A-1:0] stride    = '0;
  logic [A:0]   count     = '0;
  logic         out_ready = 1'b0;
  logic [W-1:0] rd_word   = '0;
  logic         busy;
  logic         done;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;

  int total = 0;
  int bad   = 0;

  bank_reader #(.W(W), .A(A)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .base_addr_i (base),
    .stride_i    (stride),
    .count_i     (count),
    .busy_o      (busy),
    .done_o      (done),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .rd_word_i   (rd_word),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] word_of(input logic [8:0] a);
    word_of = {7'h00, a, 16'hA5C3, 7'h00, ~a, 16'h3C5A, 23'h7F_ED00, a, 23'h00_0000, a};
  endfunction

  // Bank model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    rd_word <= rd_en ? word_of(rd_addr) : {4{32'hDEAD_BEEF}};
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [8:0] b, input logic [8:0] s, input logic [9:0] n);
    base   = b;
    stride = s;
    count  = n;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic collect(input logic [8:0] b, input logic [8:0] s, input int n,
                         input bit rnd, input string tag);
    logic [8:0] a;
    int got;
    int cyc;
    bit fin;
    a   = b;
    got = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        fin = 1'b1;
      end else begin
        if (out_valid && out_ready) begin
          chk({tag, "_data"}, out_data, word_of(a));
          chk({tag, "_last"}, 128'(out_last), 128'(got == n - 1));
          a = a + s;
          got++;
        end
        tick();
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 128'(fin), 128'(1));
    chk({tag, "_words"}, 128'(got), 128'(n));
    chk({tag, "_busy_at_done"}, 128'(busy), 128'(0));
    chk({tag, "_valid_at_done"}, 128'(out_valid), 128'(0));
    tick();
    chk({tag, "_done_one_cycle"}, 128'(done), 128'(0));
  endtask

  initial begin
    logic [7:1] e_rden;
    logic [7:1] e_valid;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_rden", 128'(rd_en), 128'(0));
    chk("rst_addr", 128'(rd_addr), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", out_data, 128'(0));
    chk("rst_last", 128'(out_last), 128'(0));
    rst_n = 1'b1;
    tick();

    // Base 0x010, stride 1, count 4, ready high: cycle-exact timeline
    out_ready = 1'b1;
    e_rden    = 7'b000_1111;
    e_valid   = 7'b011_1100;
    do_start(9'h010, 9'd1, 10'd4);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("t1_rden_c%0d", c), 128'(rd_en), 128'(e_rden[c]));
      if (e_rden[c]) chk($sformatf("t1_addr_c%0d", c), 128'(rd_addr), 128'(9'h010 + 9'(c - 1)));
      chk($sformatf("t1_valid_c%0d", c), 128'(out_valid), 128'(e_valid[c]));
      if (e_valid[c]) begin
        chk($sformatf("t1_data_c%0d", c), out_data, word_of(9'h010 + 9'(c - 3)));
        chk($sformatf("t1_last_c%0d", c), 128'(out_last), 128'(c == 6));
      end
      chk($sformatf("t1_done_c%0d", c), 128'(done), 128'(c == 7));
      chk($sformatf("t1_busy_c%0d", c), 128'(busy), 128'(c <= 6));
      tick();
    end
    chk("t1_done_c8", 128'(done), 128'(0));
    tick();

    // Address wrap: 0x1FE stride 3 -> 0x1FE, 0x001, 0x004
    do_start(9'h1FE, 9'd3, 10'd3);
    chk("t2_addr0", 128'(rd_addr), 128'(9'h1FE));
    chk("t2_rden0", 128'(rd_en), 128'(1));
    tick();
    chk("t2_addr1", 128'(rd_addr), 128'(9'h001));
    tick();
    chk("t2_addr2", 128'(rd_addr), 128'(9'h004));
    chk("t2_data0", out_data, word_of(9'h1FE));
    chk("t2_last0", 128'(out_last), 128'(0));
    tick();
    chk("t2_data1", out_data, word_of(9'h001));
    tick();
    chk("t2_data2", out_data, word_of(9'h004));
    chk("t2_last2", 128'(out_last), 128'(1));
    tick();
    chk("t2_done", 128'(done), 128'(1));
    tick();

    // Back-pressure: ready low through cycle 10, only two reads issue
    out_ready = 1'b0;
    do_start(9'h020, 9'd2, 10'd4);
    chk("t3_rden_c1", 128'(rd_en), 128'(1));
    tick();
    chk("t3_rden_c2", 128'(rd_en), 128'(1));
    chk("t3_addr_c2", 128'(rd_addr), 128'(9'h022));
    tick();
    for (int c = 3; c <= 10; c++) begin
      chk($sformatf("t3_rden_c%0d", c), 128'(rd_en), 128'(0));
      chk($sformatf("t3_valid_c%0d", c), 128'(out_valid), 128'(1));
      chk($sformatf("t3_hold_c%0d", c), out_data, word_of(9'h020));
      tick();
    end
    collect(9'h020, 9'd2, 4, 1'b0, "t3");

    // Count 0: no reads, done in cycle 1, never busy
    do_start(9'h055, 9'd1, 10'd0);
    chk("t4_done_c1", 128'(done), 128'(1));
    chk("t4_busy_c1", 128'(busy), 128'(0));
    chk("t4_rden_c1", 128'(rd_en), 128'(0));
    tick();
    chk("t4_done_c2", 128'(done), 128'(0));
    chk("t4_busy_c2", 128'(busy), 128'(0));
    tick();

    // Full bank, random back-pressure
    do_start(9'h000, 9'd1, 10'd512);
    collect(9'h000, 9'd1, 512, 1'b1, "t5");

    // Abort in cycle 4, restart the next cycle
    out_ready = 1'b1;
    do_start(9'h040, 9'd1, 10'd8);
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_valid", 128'(out_valid), 128'(0));
    chk("t6_rden", 128'(rd_en), 128'(0));
    chk("t6_done", 128'(done), 128'(0));
    do_start(9'h080, 9'd5, 10'd3);
    collect(9'h080, 9'd5, 3, 1'b0, "t6b");

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    do_start(9'h100, 9'd1, 10'd8);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t7_busy", 128'(busy), 128'(0));
    chk("t7_done", 128'(done), 128'(0));
    chk("t7_rden", 128'(rd_en), 128'(0));
    chk("t7_addr", 128'(rd_addr), 128'(0));
    chk("t7_valid", 128'(out_valid), 128'(0));
    chk("t7_data", out_data, 128'(0));
    chk("t7_last", 128'(out_last), 128'(0));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t7_post_valid%0d", c), 128'(out_valid), 128'(0));
      chk($sformatf("t7_post_busy%0d", c), 128'(busy), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
